// File: rtl/branch_resolve_queue_pkg.sv
// Shared definitions for the branch prediction slice (predictor, fetch,
// resolve queue).
//   PC_W            : default PC width used by the predictor pc_bits ports
//   dir_e           : taken / not-taken direction encoding
//   branch_entry_t  : in-flight branch record {pc, pred}
//   is_mispredict() : direction compare helper
package branch_resolve_queue_pkg;

  localparam int unsigned PC_W = 16;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } dir_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            pred;
  } branch_entry_t;

  function automatic logic is_mispredict(input logic pred, input logic taken);
    return pred != taken;
  endfunction

endpackage

// File: rtl/branch_entry_fifo.sv
// Generic circular buffer with push, pop and clear.
//   clk, reset : clock, synchronous active-high reset (pointers/count to 0)
//   push       : enqueue push_data; dropped if full and no pop this cycle
//   pop        : dequeue the head entry; ignored when empty
//   clear      : discard all entries (head <= tail); dominates push/pop
//   push_data  : entry to enqueue
//   head_data  : oldest entry (valid while !empty)
//   count      : occupancy, full, empty : status flags
module branch_entry_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 17,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [W-1:0]  push_data,
  output logic [W-1:0]  head_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          pop_ok;
  logic          push_ok;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign head_data = mem[head];

  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full buffer
  // is still accepted then.
  assign push_ok = push && !clear && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= tail;
      count <= '0;
    end else begin
      if (push_ok) tail <= tail + AW'(1);
      if (pop_ok)  head <= head + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (push_ok) mem[tail] <= push_data;
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// Tracks predicted branches from fetch to resolution and trains the
// bimodal predictor.
//   clk, reset      : clock, synchronous active-high reset
//   push_valid/pc/pred : enqueue a predicted branch from fetch
//   full            : occupancy == DEPTH, fetch must stall branches
//   resolve_valid/taken/target : oldest branch resolves (in order)
//   write_enabled, outcome, pc_bits_write : registered predictor update
//   mispredict, redirect_pc : registered fetch flush and correct next PC
//   resolve_err     : registered pulse, resolve arrived with queue empty
//   count           : current occupancy
module branch_resolve_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PC_W   = branch_resolve_queue_pkg::PC_W,
  parameter int unsigned PC_INC = 1,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push_valid,
  input  logic [PC_W-1:0] push_pc,
  input  logic            push_pred,
  output logic            full,
  input  logic            resolve_valid,
  input  logic            resolve_taken,
  input  logic [PC_W-1:0] resolve_target,
  output logic            write_enabled,
  output logic            outcome,
  output logic [PC_W-1:0] pc_bits_write,
  output logic            mispredict,
  output logic [PC_W-1:0] redirect_pc,
  output logic            resolve_err,
  output logic [CW-1:0]   count
);

  import branch_resolve_queue_pkg::*;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            pred;
  } entry_t;

  entry_t          head_entry;
  entry_t          push_entry;
  logic            empty;
  logic            hit;
  logic            mis_det;
  logic [PC_W-1:0] next_pc;

  assign push_entry = '{pc: push_pc, pred: push_pred};
  assign hit        = resolve_valid && !empty;
  assign mis_det    = hit && is_mispredict(head_entry.pred, resolve_taken);
  assign next_pc    = (resolve_taken == TAKEN) ? resolve_target
                                               : head_entry.pc + PC_W'(PC_INC);

  // A mispredict clears the queue; the clear also discards any same-cycle
  // push as wrong-path.
  branch_entry_fifo #(
    .DEPTH(DEPTH),
    .W    (PC_W + 1)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_valid),
    .pop      (resolve_valid),
    .clear    (mis_det),
    .push_data(push_entry),
    .head_data(head_entry),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      write_enabled <= 1'b0;
      outcome       <= 1'b0;
      pc_bits_write <= '0;
      mispredict    <= 1'b0;
      redirect_pc   <= '0;
      resolve_err   <= 1'b0;
    end else begin
      write_enabled <= hit;
      mispredict    <= mis_det;
      resolve_err   <= resolve_valid && empty;
      if (hit) begin
        outcome       <= resolve_taken;
        pc_bits_write <= head_entry.pc;
      end
      if (mis_det) redirect_pc <= next_pc;
    end
  end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Write-side companion to the bimodal predictor.
- Holds every predicted branch in flight, from fetch until the branch resolves in execute.
- On resolution it compares the actual direction with the stored prediction, then drives the predictor's training port (write_enabled, outcome, pc_bits_write).
- On a misprediction it also raises a flush/redirect to fetch and drops all younger wrong-path entries.

Parameters:
- DEPTH, 4: in-flight branch entries; power of two, minimum 2.
- PC_W, 16: PC width; matches the predictor's pc_bits ports.
- PC_INC, 1: fall-through increment added to the branch PC.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- push_valid  input  1  fetch enqueues a predicted branch this cycle.
- push_pc  input  PC_W  PC of the branch being enqueued.
- push_pred  input  1  prediction the bimodal predictor gave (1 = taken).
- full  output  1  combinational; count == DEPTH; fetch must stall branches.
- resolve_valid  input  1  the oldest branch resolves in execute this cycle (in-order).
- resolve_taken  input  1  actual direction.
- resolve_target  input  PC_W  actual taken target.
- write_enabled  output  1  registered; predictor update strobe.
- outcome  output  1  registered; actual direction for predictor training.
- pc_bits_write  output  PC_W  registered; PC of the resolved branch.
- mispredict  output  1  registered one-cycle pulse; fetch flush.
- redirect_pc  output  PC_W  registered; correct next PC, valid while mispredict = 1.
- resolve_err  output  1  registered one-cycle pulse; resolve_valid arrived while the queue was empty.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset:
  - All outputs 0; head, tail and count 0.
  - Entry storage contents are don't-care.
  - Reset dominates any simultaneous push or resolve.
- Storage: circular buffer of {pc, pred} entries.
  - head = oldest entry, tail = next free slot.
  - Both pointers wrap modulo DEPTH.
- Push accept rule: push is accepted iff push_valid, no mispredict is detected this cycle, and either count < DEPTH or a resolve is consuming an entry this cycle.
  - Accepted push writes entry[tail] and advances tail.
  - Push while full with no resolve is dropped silently. Fetch is required to honour full.
- Resolve on non-empty queue:
  - Take e = entry[head].
  - Next cycle: write_enabled = 1, outcome = resolve_taken, pc_bits_write = e.pc. Update latency is exactly 1 cycle.
  - Mispredict is detected if e.pred != resolve_taken.
- Mispredict:
  - Next cycle: mispredict = 1; redirect_pc = resolve_target if resolve_taken, else e.pc + PC_INC (truncated to PC_W, wraps).
  - Queue is cleared in the same edge: head = tail, count = 0.
  - A same-cycle push is discarded as wrong-path.
- Correct prediction: head advances and count decrements, adjusted +1 if a push is accepted in the same cycle.
- Resolve on empty queue:
  - No predictor update, no mispredict.
  - resolve_err pulses 1 next cycle.
  - A same-cycle push is still accepted.
- Pulse outputs: write_enabled, mispredict and resolve_err are 0 in any cycle not following a qualifying event.
  - Back-to-back resolves produce back-to-back write_enabled pulses.
- Occupancy invariant: count always equals the number of valid entries; full is asserted only when count == DEPTH.
- Reset mid-operation drops all in-flight entries; no update is emitted for them.

Decomposition:
- Shared package: PC_W, the branch-entry record {pc, pred}, and a taken/not-taken constant pair, shared with bimodal_predictor and fetch.
- One natural sub-module: branch_entry_fifo.
  - Generic circular buffer with push, pop and clear.
  - Exposes count, full and empty.
- The top level adds compare, update-register and redirect logic.

Test Plan:
- Reset, then push pc=0x0010 pred=1, then resolve taken=1 target=0x0040 -> next cycle write_enabled=1, outcome=1, pc_bits_write=0x0010, mispredict=0, count=0.
- Push pc=0x0020 pred=0, resolve taken=1 target=0x0080 -> mispredict=1, redirect_pc=0x0080, outcome=1.
- Push pc=0x0030 pred=1, resolve taken=0 -> mispredict=1, redirect_pc=0x0031.
- Push pc 0x1,0x2,0x3,0x4 -> full=1, count=4. Fifth push with no resolve -> dropped. Then push plus correct resolve in the same cycle -> count stays 4, head/tail wrap correctly.
- Fill 3 entries; mispredict on the oldest with a simultaneous push -> count=0 next cycle, the push is dropped, and later resolves yield resolve_err=1.
- Push pc=0xFFFF pred=1, resolve taken=0 -> redirect_pc=0x0000 (wrap). Separately, assert reset mid-queue -> all outputs 0 and count=0 on the next cycle.
